// File: rtl/m2vidct_sparse_if.sv
// m2vidct_sparse_if: block control, coefficient handshake and pixel read bus of the sparse IDCT
interface m2vidct_sparse_if #(
  parameter int COEF_W = 12,
  parameter int OUT_W  = 9,
  parameter int LANES  = 2
);
  logic                        ready_idct;
  logic                        block_start;
  logic                        coef_valid;
  logic                        coef_ready;
  logic [5:0]                  coef_pos;
  logic signed [COEF_W-1:0]    coef_data;
  logic                        coef_last;
  logic                        block_done;
  logic                        pixel_avail;
  logic [$clog2(64/LANES)-1:0] pixel_addr;
  logic [LANES*OUT_W-1:0]      pixel_data;
  logic                        pixel_release;
  modport master (
    input  ready_idct, coef_ready, block_done, pixel_avail, pixel_data,
    output block_start, coef_valid, coef_pos, coef_data, coef_last, pixel_addr, pixel_release
  );
  modport slave (
    output ready_idct, coef_ready, block_done, pixel_avail, pixel_data,
    input  block_start, coef_valid, coef_pos, coef_data, coef_last, pixel_addr, pixel_release
  );
endinterface

// File: rtl/m2vidct_sparse.sv
// m2vidct_sparse: sparse-input 8x8 MPEG2 inverse DCT with DC fast path and two-page output buffer
module m2vidct_sparse #(
  parameter int COEF_W = 12,
  parameter int OUT_W  = 9,
  parameter int COS_W  = 14,
  parameter int ACC_W  = 32,
  parameter int MACS   = 2,
  parameter int LANES  = 2
) (
  input logic             clk,
  input logic             reset_n,
  input logic             softreset,
  m2vidct_sparse_if.slave pif
);
  localparam int PH_N = 8 / MACS;
  localparam int COL_SH = 11;
  localparam int ROW_SH = 2 * (COS_W - 1) - COL_SH;
  localparam logic signed [ACC_W-1:0] COL_RND = ACC_W'(2 ** (COL_SH - 1));
  localparam logic signed [ACC_W-1:0] ROW_RND = ACC_W'(2 ** (ROW_SH - 1));
  localparam logic signed [ACC_W-1:0] DC_RND = ACC_W'(4);
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] PMIN = ~PMAX;
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DCFILL, ROW, DONE} state_t;
  state_t state, nxt;
  logic signed [ACC_W-1:0] ram [64];
  logic signed [OUT_W-1:0] obuf [128];
  logic [1:0] filled;
  logic wpage, rpage, busy, got_last, dc_only, ph_end, take;
  logic [5:0] cnt;
  logic [2:0] ph, cu, cv;
  logic signed [COEF_W-1:0] cf;
  logic signed [COEF_W+5:0] dc_sum;
  logic signed [ACC_W-1:0] racc, rsum, row_fin;
  logic [2:0] tv [MACS];
  logic [5:0] mac_idx [MACS];
  logic signed [ACC_W-1:0] mac_prod [MACS];
  logic signed [17:0] gr [MACS];
  logic signed [OUT_W-1:0] row_pix, dc_pix;
  function automatic logic signed [COS_W-1:0] cosv(input logic [2:0] x, input logic [2:0] u);
    logic [4:0] k;
    logic [3:0] j;
    logic signed [COS_W-1:0] mag;
    k = 5'({3'b0, x, 1'b1} * {4'b0, u});
    j = k[3] ? 4'(-k[3:0]) : k[3:0];
    case (j)
      4'd1: mag = COS_W'(4017);
      4'd2: mag = COS_W'(3784);
      4'd3: mag = COS_W'(3406);
      4'd4: mag = COS_W'(2896);
      4'd5: mag = COS_W'(2276);
      4'd6: mag = COS_W'(1567);
      4'd7: mag = COS_W'(799);
      default: mag = '0;
    endcase
    return u == 3'd0 ? COS_W'(2896) : (k[4] ^ k[3]) ? -mag : mag;
  endfunction
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    return a > PMAX ? PMAX[OUT_W-1:0] : a < PMIN ? PMIN[OUT_W-1:0] : a[OUT_W-1:0];
  endfunction
  assign ph_end = ph == 3'(PH_N - 1);
  assign take = pif.coef_valid && pif.coef_ready;
  assign pif.block_done = state == DONE;
  assign pif.pixel_avail = filled[rpage];
  // next-state and handshake outputs
  always_comb begin
    nxt = state;
    pif.ready_idct = 1'b0;
    pif.coef_ready = 1'b0;
    case (state)
      IDLE: begin
        pif.ready_idct = !filled[wpage];
        nxt = pif.block_start && !filled[wpage] ? CLEAR : IDLE;
      end
      CLEAR: nxt = cnt == 6'(64 - MACS) ? ACCUM : CLEAR;
      ACCUM: begin
        pif.coef_ready = !got_last && (!busy || ph_end);
        nxt = busy && ph_end && got_last ? (dc_only ? DCFILL : ROW) : ACCUM;
      end
      DCFILL: nxt = cnt == 6'(64 - LANES) ? DONE : DCFILL;
      ROW: nxt = ph_end && cnt == 6'd63 ? DONE : ROW;
      default: nxt = IDLE;
    endcase
  end
  // MAC operands for the column scatter and row gather; the column result keeps 2 guard bits so the row pass finishes the 2^26 scaling
  always_comb begin
    rsum = '0;
    for (int m = 0; m < MACS; m++) begin
      tv[m] = 3'(int'(ph) * MACS + m);
      mac_idx[m] = {cv, tv[m]};
      mac_prod[m] = cf * cosv(tv[m], cu);
      gr[m] = 18'((ram[{tv[m], cnt[2:0]}] + COL_RND) >>> COL_SH);
      rsum = rsum + cosv(cnt[5:3], tv[m]) * gr[m];
    end
    row_fin = racc + rsum;
    row_pix = sat((row_fin + ROW_RND) >>> ROW_SH);
    dc_pix = sat((ACC_W'(dc_sum) + DC_RND) >>> 3);
  end
  // state register, coefficient pipeline, counters and page ownership
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || softreset) begin
      state <= IDLE;
      filled <= '0;
      wpage <= 1'b0;
      rpage <= 1'b0;
      cnt <= '0;
      ph <= '0;
      busy <= 1'b0;
      got_last <= 1'b0;
      dc_only <= 1'b0;
      dc_sum <= '0;
      racc <= '0;
      cu <= '0;
      cv <= '0;
      cf <= '0;
    end else begin
      state <= nxt;
      if (state == CLEAR) begin
        cnt <= cnt + 6'(MACS);
        dc_only <= 1'b1;
        got_last <= 1'b0;
        busy <= 1'b0;
        dc_sum <= '0;
      end
      if (state == DCFILL) cnt <= cnt + 6'(LANES);
      if (take) begin
        busy <= 1'b1;
        ph <= '0;
        cu <= pif.coef_pos[2:0];
        cv <= pif.coef_pos[5:3];
        cf <= pif.coef_data;
        got_last <= pif.coef_last;
        if (pif.coef_pos != 6'd0) dc_only <= 1'b0;
        else dc_sum <= dc_sum + (COEF_W + 6)'(pif.coef_data);
      end else if (state == ACCUM && busy) begin
        ph <= ph_end ? 3'd0 : ph + 3'd1;
        busy <= !ph_end;
      end
      if (state == ROW) begin
        ph <= ph_end ? 3'd0 : ph + 3'd1;
        racc <= ph_end ? '0 : row_fin;
        cnt <= ph_end ? cnt + 6'd1 : cnt;
      end
      if (state == DONE) begin
        filled[wpage] <= 1'b1;
        wpage <= !wpage;
      end
      if (pif.pixel_release && filled[rpage]) begin
        filled[rpage] <= 1'b0;
        rpage <= !rpage;
      end
      if (nxt != state) begin
        cnt <= '0;
        ph <= '0;
        racc <= '0;
      end
    end
  end
  // intermediate RAM, output pages and registered read port; contents need no reset
  always_ff @(posedge clk) begin
    for (int m = 0; m < MACS; m++) begin
      if (state == CLEAR) ram[6'(int'(cnt) + m)] <= '0;
      if (state == ACCUM && busy) ram[mac_idx[m]] <= ram[mac_idx[m]] + mac_prod[m];
    end
    if (state == ROW && ph_end) obuf[{wpage, cnt}] <= row_pix;
    for (int k = 0; k < LANES; k++) begin
      if (state == DCFILL) obuf[{wpage, 6'(int'(cnt) + k)}] <= dc_pix;
      pif.pixel_data[k*OUT_W +: OUT_W] <= obuf[{rpage, 6'(int'(pif.pixel_addr) * LANES + k)}];
    end
  end
endmodule
